gpio_cmd_responder: RTL and testbench

GPIO_CMD_RESPONDER -- requirements
Module: gpio_cmd_responder

---
 rtl/gpio_cmd_responder.sv | 191 +++++++++++++++++++
 tb/tb_gpio_cmd_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cmd_responder.sv
// Host command responder driven over a toggle-handshake GPIO word.
// Decodes image/kernel writes, convolution start, result reads, status and soft reset.
module gpio_cmd_responder #(
  parameter int GPIO_D     = 32,
  parameter int BIT_LEN    = 8,
  parameter int NB_ADDRESS = 10,
  parameter int RAM_WIDTH  = 13,
  parameter int M_LEN      = 3
) (
  input  logic                            CLK100MHZ,
  input  logic                            i_reset,
  input  logic [GPIO_D-1:0]               i_gpio_data,
  output logic [GPIO_D-1:0]               o_gpio_data,
  output logic                            o_mem_wr_en,
  output logic [NB_ADDRESS-1:0]           o_mem_addr,
  output logic [BIT_LEN-1:0]              o_mem_data,
  output logic                            o_mem_rd_en,
  input  logic [RAM_WIDTH-1:0]            i_mem_rd_data,
  output logic [M_LEN*M_LEN*BIT_LEN-1:0]  o_kernel,
  output logic                            o_conv_start,
  input  logic                            i_conv_done,
  output logic                            o_soft_reset,
  output logic                            o_led
);

  localparam int KCOUNT = M_LEN * M_LEN;
  localparam logic [NB_ADDRESS-1:0] K_LAST = NB_ADDRESS'(KCOUNT - 1);

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_SOFT_RST = 3'b001;
  localparam logic [2:0] OP_WR_IMG   = 3'b010;
  localparam logic [2:0] OP_WR_KER   = 3'b011;
  localparam logic [2:0] OP_START    = 3'b100;
  localparam logic [2:0] OP_RD_RES   = 3'b101;
  localparam logic [2:0] OP_STATUS   = 3'b110;

  typedef enum logic [2:0] {IDLE, EXEC, RD_WAIT, RST_HOLD, ACK} state_t;

  state_t state_reg, state_next;

  logic [GPIO_D-1:0]     sync1_reg, sync2_reg;
  logic                  last_toggle_reg;
  logic [2:0]            op_reg;
  logic                  toggle_reg;
  logic [NB_ADDRESS-1:0] addr_reg;
  logic [BIT_LEN-1:0]    data_reg;
  logic [1:0]            cnt_reg;
  logic                  busy_reg, error_reg, ack_reg, rd_ok_reg;
  logic [RAM_WIDTH-1:0]  result_reg;
  logic [BIT_LEN-1:0]    coef_reg [KCOUNT];

  logic new_cmd, wr_en, rd_en, conv_start, soft_reset, ker_load, set_error, soft_clr;
  logic unused_sync;

  assign unused_sync = ^sync2_reg;
  assign new_cmd = (state_reg == IDLE) && (sync2_reg[28] != last_toggle_reg);

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    conv_start = 1'b0;
    soft_reset = 1'b0;
    ker_load   = 1'b0;
    set_error  = 1'b0;
    soft_clr   = 1'b0;
    case (state_reg)
      IDLE: if (new_cmd) state_next = EXEC;
      EXEC: begin
        state_next = ACK;
        case (op_reg)
          OP_SOFT_RST: begin
            state_next = RST_HOLD;
            soft_clr   = 1'b1;
          end
          OP_RD_RES: begin
            // Rejected reads still walk RD_WAIT so the ack timing stays uniform.
            state_next = RD_WAIT;
            if (busy_reg) set_error = 1'b1;
            else          rd_en     = 1'b1;
          end
          OP_WR_IMG: begin
            if (busy_reg) set_error = 1'b1;
            else          wr_en     = 1'b1;
          end
          OP_WR_KER: begin
            if (busy_reg || addr_reg > K_LAST) set_error = 1'b1;
            else                               ker_load  = 1'b1;
          end
          OP_START: begin
            if (busy_reg) set_error  = 1'b1;
            else          conv_start = 1'b1;
          end
          OP_NOP, OP_STATUS: ;
          default: set_error = 1'b1;
        endcase
      end
      RD_WAIT: if (cnt_reg == 2'd1) state_next = ACK;
      RST_HOLD: begin
        soft_reset = 1'b1;
        if (cnt_reg == 2'd3) state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge i_reset) begin
    if (i_reset) begin
      sync1_reg       <= '0;
      sync2_reg       <= '0;
      last_toggle_reg <= 1'b0;
      op_reg          <= '0;
      toggle_reg      <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      error_reg       <= 1'b0;
      ack_reg         <= 1'b0;
      rd_ok_reg       <= 1'b0;
      result_reg      <= '0;
    end else begin
      sync1_reg <= i_gpio_data;
      sync2_reg <= sync1_reg;
      if (new_cmd) begin
        op_reg     <= sync2_reg[31:29];
        toggle_reg <= sync2_reg[28];
        addr_reg   <= sync2_reg[8 +: NB_ADDRESS];
        data_reg   <= sync2_reg[BIT_LEN-1:0];
      end
      if (state_reg == EXEC) begin
        cnt_reg   <= '0;
        rd_ok_reg <= rd_en;
      end else if (state_reg == RD_WAIT || state_reg == RST_HOLD) begin
        cnt_reg <= cnt_reg + 2'd1;
      end
      if (soft_clr) begin
        busy_reg <= 1'b0;
      end else begin
        if (i_conv_done) busy_reg <= 1'b0;
        if (conv_start)  busy_reg <= 1'b1;
      end
      if (soft_clr)       error_reg <= 1'b0;
      else if (set_error) error_reg <= 1'b1;
      if (soft_clr)
        result_reg <= '0;
      else if (state_reg == RD_WAIT && state_next == ACK && rd_ok_reg)
        result_reg <= i_mem_rd_data;
      // Ack becomes visible on entry to ACK; the host-side toggle is retired on exit.
      if (state_reg != ACK && state_next == ACK) ack_reg <= toggle_reg;
      if (state_reg == ACK) last_toggle_reg <= toggle_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < KCOUNT; gi++) begin : g_coef
      always_ff @(posedge CLK100MHZ or posedge i_reset) begin
        if (i_reset)
          coef_reg[gi] <= '0;
        else if (soft_clr)
          coef_reg[gi] <= '0;
        else if (ker_load && addr_reg == NB_ADDRESS'(gi))
          coef_reg[gi] <= data_reg;
      end
      assign o_kernel[gi*BIT_LEN +: BIT_LEN] = coef_reg[gi];
    end
  endgenerate

  always_comb begin
    o_gpio_data                  = '0;
    o_gpio_data[31]              = ack_reg;
    o_gpio_data[30]              = busy_reg;
    o_gpio_data[29]              = error_reg;
    o_gpio_data[RAM_WIDTH-1:0]   = result_reg;
  end

  assign o_mem_wr_en  = wr_en;
  assign o_mem_rd_en  = rd_en;
  assign o_mem_addr   = addr_reg;
  assign o_mem_data   = data_reg;
  assign o_conv_start = conv_start;
  assign o_soft_reset = soft_reset;
  assign o_led        = busy_reg;

endmodule

// File: tb/tb_gpio_cmd_responder.sv
// Directed bench for gpio_cmd_responder: table of host commands plus hand-built
// sequences for busy handling, result reads and reset in the middle of a read.
module tb_gpio_cmd_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        mem_wr_en, mem_rd_en, conv_start, conv_done, soft_reset, led;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data;
  logic [12:0] mem_rd_data;
  logic [71:0] kernel;
  logic [1:0]  rd_pipe;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, start_cnt = 0, srst_cnt = 0;
  logic [9:0] wr_addr_seen, rd_addr_seen;
  logic [7:0] wr_data_seen;
  logic       host_tog = 1'b0;

  always #5 clk = ~clk;

  gpio_cmd_responder dut (
    .CLK100MHZ    (clk),
    .i_reset      (rst),
    .i_gpio_data  (gpio_in),
    .o_gpio_data  (gpio_out),
    .o_mem_wr_en  (mem_wr_en),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_rd_en  (mem_rd_en),
    .i_mem_rd_data(mem_rd_data),
    .o_kernel     (kernel),
    .o_conv_start (conv_start),
    .i_conv_done  (conv_done),
    .o_soft_reset (soft_reset),
    .o_led        (led)
  );

  // Memory model: read data valid two cycles after the read strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pipe <= 2'b00;
    else     rd_pipe <= {rd_pipe[0], mem_rd_en};
  end
  assign mem_rd_data = rd_pipe[1] ? 13'h1ABC : 13'h0000;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_cnt       = wr_cnt + 1;
      wr_addr_seen = mem_addr;
      wr_data_seen = mem_data;
    end
    if (mem_rd_en) begin
      rd_cnt       = rd_cnt + 1;
      rd_addr_seen = mem_addr;
    end
    if (conv_start) start_cnt = start_cnt + 1;
    if (soft_reset) srst_cnt  = srst_cnt + 1;
  end

  typedef struct {
    logic [2:0] op;
    logic [9:0] addr;
    logic [7:0] data;
    int         lat;
    int         d_wr;
    int         d_rd;
    int         d_start;
    int         d_srst;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic [2:0] op, logic [9:0] addr, logic [7:0] data, int lat,
                              int d_wr, int d_start, int d_srst, logic err, logic busy);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.lat = lat;
    v.d_wr = d_wr; v.d_rd = 0; v.d_start = d_start; v.d_srst = d_srst;
    v.err = err; v.busy = busy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, got);
    end
  endtask

  task automatic drive_cmd(logic [2:0] op, logic [9:0] addr, logic [7:0] data);
    host_tog      = ~host_tog;
    gpio_in       = '0;
    gpio_in[31:29] = op;
    gpio_in[28]   = host_tog;
    gpio_in[17:8] = addr;
    gpio_in[7:0]  = data;
  endtask

  // Returns cycles from sync-stage-2 change to ack, or -1 on timeout.
  task automatic wait_ack(int pre, output int lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (gpio_out[31] !== host_tog && n < 40);
    lat = (gpio_out[31] === host_tog) ? n - pre : -1;
  endtask

  task automatic send_cmd(logic [2:0] op, logic [9:0] addr, logic [7:0] data, output int lat);
    drive_cmd(op, addr, data);
    wait_ack(2, lat);
  endtask

  task automatic run_vec(int i);
    int lat, w0, r0, s0, q0;
    vec_t v;
    v = vecs[i];
    w0 = wr_cnt; r0 = rd_cnt; s0 = start_cnt; q0 = srst_cnt;
    send_cmd(v.op, v.addr, v.data, lat);
    $display("[TB] vec %0d op=%0d addr=%0h data=%0h lat=%0d gpio=%08h", i, v.op, v.addr, v.data, lat, gpio_out);
    chk($sformatf("v%0d_latency", i), lat, v.lat);
    chk($sformatf("v%0d_wr_pulses", i), wr_cnt - w0, v.d_wr);
    chk($sformatf("v%0d_rd_pulses", i), rd_cnt - r0, v.d_rd);
    chk($sformatf("v%0d_start_pulses", i), start_cnt - s0, v.d_start);
    chk($sformatf("v%0d_srst_cycles", i), srst_cnt - q0, v.d_srst);
    chk($sformatf("v%0d_error", i), gpio_out[29], v.err);
    chk($sformatf("v%0d_busy", i), gpio_out[30], v.busy);
    chk($sformatf("v%0d_led", i), led, v.busy);
    if (v.d_wr > 0) begin
      chk($sformatf("v%0d_wr_addr", i), wr_addr_seen, v.addr);
      chk($sformatf("v%0d_wr_data", i), wr_data_seen, v.data);
    end
  endtask

  initial begin
    int lat, r0;
    vecs[0] = mk(3'b000, 10'h000, 8'h00, 2, 0, 0, 0, 1'b0, 1'b0);
    vecs[1] = mk(3'b010, 10'h005, 8'hA7, 2, 1, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++)
      vecs[2+k] = mk(3'b011, 10'(k), 8'(k+1), 2, 0, 0, 0, 1'b0, 1'b0);
    vecs[11] = mk(3'b011, 10'h009, 8'h55, 2, 0, 0, 0, 1'b1, 1'b0);
    vecs[12] = mk(3'b110, 10'h000, 8'h00, 2, 0, 0, 0, 1'b1, 1'b0);
    vecs[13] = mk(3'b001, 10'h000, 8'h00, 6, 0, 0, 4, 1'b0, 1'b0);
    vecs[14] = mk(3'b100, 10'h000, 8'h00, 2, 0, 1, 0, 1'b0, 1'b1);
    vecs[15] = mk(3'b010, 10'h010, 8'h33, 2, 0, 0, 0, 1'b1, 1'b1);
    vecs[16] = mk(3'b100, 10'h000, 8'h00, 2, 0, 0, 0, 1'b1, 1'b1);

    rst = 1'b1; gpio_in = '0; conv_done = 1'b0;
    repeat (3) tick();
    chk("reset_gpio_out", gpio_out, 32'h0);
    chk("reset_kernel", kernel, 72'h0);
    rst = 1'b0;
    tick();
    chk("post_reset_gpio_out", gpio_out, 32'h0);

    for (int i = 0; i <= 11; i++) run_vec(i);
    chk("kernel_after_idx9", kernel, 72'h090807060504030201);
    for (int i = 12; i <= 13; i++) run_vec(i);
    chk("kernel_after_soft_rst", kernel, 72'h0);
    for (int i = 14; i <= 16; i++) run_vec(i);

    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("busy_after_done", gpio_out[30], 1'b0);
    chk("led_after_done", led, 1'b0);

    r0 = rd_cnt;
    send_cmd(3'b101, 10'h3FF, 8'h00, lat);
    $display("[TB] rd_res lat=%0d gpio=%08h", lat, gpio_out);
    chk("rd_latency", lat, 4);
    chk("rd_pulses", rd_cnt - r0, 1);
    chk("rd_addr", rd_addr_seen, 10'h3FF);
    chk("rd_result", gpio_out[12:0], 13'h1ABC);

    send_cmd(3'b001, 10'h000, 8'h00, lat);
    $display("[TB] soft_rst lat=%0d gpio=%08h", lat, gpio_out);
    chk("srst2_latency", lat, 6);
    chk("srst2_result_cleared", gpio_out[12:0], 13'h0);
    chk("srst2_error_cleared", gpio_out[29], 1'b0);

    send_cmd(3'b111, 10'h000, 8'h00, lat);
    $display("[TB] illegal lat=%0d gpio=%08h", lat, gpio_out);
    chk("illegal_latency", lat, 2);
    chk("illegal_error", gpio_out[29], 1'b1);

    // The read that gets reset must carry toggle=1 so it is re-seen after release.
    if (host_tog) begin
      send_cmd(3'b000, 10'h000, 8'h00, lat);
      chk("nop_align_latency", lat, 2);
    end
    drive_cmd(3'b101, 10'h3FF, 8'h00);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_in_rdwait_gpio", gpio_out, 32'h0);
    repeat (3) tick();
    chk("rst_held_gpio", gpio_out, 32'h0);
    chk("rst_held_soft_reset", soft_reset, 1'b0);
    r0 = rd_cnt;
    rst = 1'b0;
    wait_ack(0, lat);
    $display("[TB] re-exec after reset lat=%0d gpio=%08h", lat, gpio_out);
    chk("reexec_cycles_from_release", lat, 6);
    chk("reexec_rd_pulses", rd_cnt - r0, 1);
    chk("reexec_result", gpio_out[12:0], 13'h1ABC);
    chk("reexec_error", gpio_out[29], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
